// File: rtl/mux_rr_arbiter_pkg.sv
// mux_arb_pkg: shared sizes, FSM encoding and default hold
// limit for the 4-lane round-robin arbiter.
package mux_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;
  localparam int DEF_MAX_HOLD = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// mux_rr_arbiter_if: requester bus, downstream stream and
// grant/select outputs of the round-robin arbiter.
interface mux_rr_arbiter_if
  import mux_arb_pkg::*;
#(
  parameter int DATA_W = 4
);

  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        last;
  logic [N_REQ*DATA_W-1:0] data_in;
  logic                    out_ready;
  logic                    out_valid;
  logic [DATA_W-1:0]       out_data;
  logic                    out_last;
  logic [N_REQ-1:0]        grant;
  logic [SEL_W-1:0]        sel;

  modport master (
    output req,
    output last,
    output data_in,
    output out_ready,
    input  out_valid,
    input  out_data,
    input  out_last,
    input  grant,
    input  sel
  );

  modport slave (
    input  req,
    input  last,
    input  data_in,
    input  out_ready,
    output out_valid,
    output out_data,
    output out_last,
    output grant,
    output sel
  );

endinterface

// File: rtl/mux_rr_arbiter_pick.sv
// mux_rr_pick: rotate-priority picker, search starts at ptr
// and wraps mod 4; the first set request wins.
module mux_rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             hit,
  output logic [SEL_W-1:0] idx,
  output logic [N_REQ-1:0] onehot
);

  logic [SEL_W-1:0] j;

  // walk from farthest to nearest so the nearest hit wins
  always_comb begin
    hit = 1'b0;
    idx = '0;
    j   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = ptr + SEL_W'(k);
      if (req[j]) begin
        hit = 1'b1;
        idx = j;
      end
    end
  end

  assign onehot = hit ? (N_REQ'(1) << idx) : '0;

endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin grant + lane select stream.
// Optional grant timeout: define MUX_ARB_TIMEOUT_EN.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W = 4
`ifdef MUX_ARB_TIMEOUT_EN
  ,
  parameter int MAX_HOLD = DEF_MAX_HOLD
`endif
) (
  input logic clk,
  input logic rst,
  mux_rr_arbiter_if.slave bus
);

  state_t           state;
  logic [N_REQ-1:0] grant_q;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] ptr;

  logic             hit;
  logic [SEL_W-1:0] idx;
  logic [N_REQ-1:0] onehot;

  logic              busy;
  logic              vld;
  logic              xfer;
  logic              tmo;
  logic [DATA_W-1:0] lane;

  mux_rr_pick u_pick (
    .req    (bus.req),
    .ptr    (ptr),
    .hit    (hit),
    .idx    (idx),
    .onehot (onehot)
  );

  // 4:1 lane mux driven by the registered select
  assign lane = bus.data_in[DATA_W*sel_q +: DATA_W];

  assign busy = (state == ST_BUSY);
  assign vld  = busy & bus.req[sel_q];
  assign xfer = vld & bus.out_ready;

`ifdef MUX_ARB_TIMEOUT_EN
  logic [7:0] beats;
  assign tmo = (beats == 8'(MAX_HOLD - 1));
`else
  assign tmo = 1'b0;
`endif

  assign bus.out_valid = vld;
  assign bus.out_data  = busy ? lane : '0;
  assign bus.out_last  = vld & bus.last[sel_q];
  assign bus.grant     = grant_q;
  assign bus.sel       = sel_q;

  // grant FSM: pick in IDLE, hold until last/withdraw/timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      ptr     <= '0;
`ifdef MUX_ARB_TIMEOUT_EN
      beats   <= '0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (hit) begin
            state   <= ST_BUSY;
            grant_q <= onehot;
            sel_q   <= idx;
            ptr     <= idx + SEL_W'(1);
`ifdef MUX_ARB_TIMEOUT_EN
            beats   <= '0;
`endif
          end
        end
        ST_BUSY: begin
          if (!bus.req[sel_q] ||
              (xfer && (bus.last[sel_q] || tmo))) begin
            state   <= ST_IDLE;
            grant_q <= '0;
          end
`ifdef MUX_ARB_TIMEOUT_EN
          if (xfer) beats <= beats + 8'd1;
`endif
        end
        default: begin
          state   <= ST_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed steps, beat scoreboard and
// immediate-assertion checks for mux_rr_arbiter.
module tb_mux_rr_arbiter;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [4:0] sb[$];

  mux_rr_arbiter_if #(.DATA_W(4)) bus ();

`ifdef MUX_ARB_TIMEOUT_EN
  mux_rr_arbiter #(.DATA_W(4), .MAX_HOLD(4)) dut (
`else
  mux_rr_arbiter #(.DATA_W(4)) dut (
`endif
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every accepted beat must match the queue head
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", {11'd0, bus.out_data, bus.out_last}, 16'hFFFF);
        end else begin
          chk("beat", {11'd0, bus.out_data, bus.out_last}, {11'd0, sb.pop_front()});
        end
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.req       = 4'b1111;
    bus.last      = 4'b0000;
    bus.data_in   = 16'h3C21;
    bus.out_ready = 1'b0;

    // reset state
    tick(); tick();
    #4;
    chk("rst_grant", 16'(bus.grant), 16'h0);
    chk("rst_sel", 16'(bus.sel), 16'h0);
    chk("rst_valid", 16'(bus.out_valid), 16'h0);
    chk("rst_data", 16'(bus.out_data), 16'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("first_grant", 16'(bus.grant), 16'h1);
    bus.req = 4'b0000;
    tick();
    chk("withdraw_idle", 16'(bus.grant), 16'h0);

    // single requester, three beats of lane 2
    bus.req = 4'b0100;
    bus.out_ready = 1'b1;
    tick();
    sb.push_back({4'hC, 1'b0});
    chk("single_sel", 16'(bus.sel), 16'h2);
    chk("single_grant", 16'(bus.grant), 16'h4);
    tick();
    sb.push_back({4'hC, 1'b0});
    tick();
    bus.last = 4'b0100;
    sb.push_back({4'hC, 1'b1});
    #4;
    chk("single_last", 16'(bus.out_last), 16'h1);
    tick();
    bus.req = 4'b0000;
    bus.last = 4'b0000;
    chk("single_release", 16'(bus.grant), 16'h0);
    chk("single_noval", 16'(bus.out_valid), 16'h0);

    // fairness from a fresh pointer
    rst = 1'b1;
    tick();
    bus.req = 4'b1111;
    bus.last = 4'b1111;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      sb.push_back({bus.data_in[4*(k%4) +: 4], 1'b1});
      chk($sformatf("fair_grant%0d", k), 16'(bus.grant), 16'(4'b1 << (k % 4)));
      tick();
      chk($sformatf("fair_idle%0d", k), 16'(bus.grant), 16'h0);
    end
    bus.req = 4'b0000;
    bus.last = 4'b0000;
    tick();

    // backpressure
    bus.req = 4'b0010;
    bus.last = 4'b0010;
    bus.out_ready = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      #4;
      chk($sformatf("bp_hold%0d", k), 16'(bus.grant), 16'h2);
      tick();
    end
    bus.out_ready = 1'b1;
    sb.push_back({4'h2, 1'b1});
    chk("bp_hold3", 16'(bus.grant), 16'h2);
    tick();
    bus.req = 4'b0000;
    bus.last = 4'b0000;
    chk("bp_release", 16'(bus.grant), 16'h0);
    tick();

    // withdrawal of requester 3, pointer wraps to 0
    bus.req = 4'b1000;
    tick();
    chk("wd_grant3", 16'(bus.grant), 16'h8);
    sb.push_back({4'h3, 1'b0});
    tick();
    bus.req = 4'b0001;
    #4;
    chk("wd_novalid", 16'(bus.out_valid), 16'h0);
    tick();
    bus.out_ready = 1'b0;
    chk("wd_idle", 16'(bus.grant), 16'h0);
    tick();
    chk("wrap_grant0", 16'(bus.grant), 16'h1);
    chk("wrap_data", 16'(bus.out_data), 16'h1);

    // async reset while busy
    #2;
    rst = 1'b1;
    #1;
    chk("arst_grant", 16'(bus.grant), 16'h0);
    chk("arst_valid", 16'(bus.out_valid), 16'h0);
    chk("arst_data", 16'(bus.out_data), 16'h0);
    tick();
    bus.req = 4'b0000;
    rst = 1'b0;
    tick();

    // timeout / unlimited hold, requester 0 never sends last
    bus.req = 4'b0011;
    bus.out_ready = 1'b1;
    tick();
`ifdef MUX_ARB_TIMEOUT_EN
    for (int b = 0; b < 4; b++) begin
      sb.push_back({4'h1, 1'b0});
      #4;
      chk($sformatf("to_grant%0d", b), 16'(bus.grant), 16'h1);
      chk($sformatf("to_last%0d", b), 16'(bus.out_last), 16'h0);
      tick();
    end
    bus.out_ready = 1'b0;
    chk("to_release", 16'(bus.grant), 16'h0);
    tick();
    chk("to_next", 16'(bus.grant), 16'h2);
`else
    for (int b = 0; b < 22; b++) begin
      sb.push_back({4'h1, 1'b0});
      chk($sformatf("hold%0d", b), 16'(bus.grant), 16'h1);
      tick();
    end
    bus.out_ready = 1'b0;
    bus.req = 4'b0000;
    tick();
    chk("hold_release", 16'(bus.grant), 16'h0);
`endif
    bus.req = 4'b0000;
    tick();
    tick();
    chk("sb_empty", 16'(sb.size()), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
